instr_stream_encoder: RTL and testbench

- Inverse of the pipeline control decoder: accepts symbolic instruction requests (mnemonic + register/immediate fields) over a valid/ready handshake.
- Encodes each request into the 32-bit instruction word our decoder expects, and writes it sequentially into instruction memory through a back-pressured write port.
- Used as the program loader feeding IF-stage memory before and between test runs.

---
 rtl/instr_enc_pkg.sv | 43 ++++
 rtl/instr_word_pack.sv | 47 ++++
 rtl/instr_stream_encoder.sv | 149 ++++++++++++++
 tb/tb_instr_stream_encoder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_enc_pkg.sv
// Shared types and encoding constants for the instruction stream encoder.
package instr_enc_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR   = 4'd3,
    OP_SLT  = 4'd4,  OP_SLTO = 4'd5,  OP_XORI = 4'd6,  OP_SLTI = 4'd7,
    OP_ANDI = 4'd8,  OP_LUI  = 4'd9,  OP_LW   = 4'd10, OP_SW   = 4'd11,
    OP_BEQ  = 4'd12, OP_J    = 4'd13, OP_NOP  = 4'd14, OP_ILL  = 4'd15
  } op_e;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_e;

  localparam logic [5:0] OPC_RTYPE = 6'b000100;
  localparam logic [5:0] OPC_SLTO  = 6'b000111;
  localparam logic [5:0] OPC_XORI  = 6'b001001;
  localparam logic [5:0] OPC_SLTI  = 6'b001000;
  localparam logic [5:0] OPC_ANDI  = 6'b000110;
  localparam logic [5:0] OPC_LUI   = 6'b000101;
  localparam logic [5:0] OPC_LW    = 6'b000000;
  localparam logic [5:0] OPC_SW    = 6'b000001;
  localparam logic [5:0] OPC_BEQ   = 6'b000010;
  localparam logic [5:0] OPC_J     = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [31:0] NOP_WORD = 32'h1000_0000;

  function automatic logic [31:0] r_form(input logic [5:0] opc, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [5:0] fn);
    return {opc, rs, rt, rd, 5'b0, fn};
  endfunction

  function automatic logic [31:0] i_form(input logic [5:0] opc, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_word_pack.sv
// Combinational encoder: symbolic op + fields -> 32-bit instruction word.
module instr_word_pack
  import instr_enc_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal,
  output logic        is_branch
);

  always_comb begin
    word      = 32'h0;
    illegal   = 1'b0;
    is_branch = 1'b0;
    case (op)
      OP_ADD:  word = r_form(OPC_RTYPE, rs, rt, rd, FN_ADD);
      OP_SUB:  word = r_form(OPC_RTYPE, rs, rt, rd, FN_SUB);
      OP_AND:  word = r_form(OPC_RTYPE, rs, rt, rd, FN_AND);
      OP_OR:   word = r_form(OPC_RTYPE, rs, rt, rd, FN_OR);
      OP_SLT:  word = r_form(OPC_RTYPE, rs, rt, rd, FN_SLT);
      OP_SLTO: word = r_form(OPC_SLTO,  rs, rt, rd, 6'b0);
      OP_XORI: word = i_form(OPC_XORI, rs, rt, imm);
      OP_SLTI: word = i_form(OPC_SLTI, rs, rt, imm);
      OP_ANDI: word = i_form(OPC_ANDI, rs, rt, imm);
      // LUI has no source register; the decoder expects rs=0.
      OP_LUI:  word = i_form(OPC_LUI, 5'd0, rt, imm);
      OP_LW:   word = i_form(OPC_LW, rs, rt, imm);
      OP_SW:   word = i_form(OPC_SW, rs, rt, imm);
      OP_BEQ: begin
        word      = i_form(OPC_BEQ, rs, rt, imm);
        is_branch = 1'b1;
      end
      OP_J: begin
        word      = {OPC_J, target};
        is_branch = 1'b1;
      end
      OP_NOP:  word = NOP_WORD;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_stream_encoder.sv
// Program loader: encodes symbolic requests and streams them into instruction memory.
// Optional NOP padding after BEQ/J is enabled by defining INSTR_ENC_NOP_PAD_EN.
module instr_stream_encoder
  import instr_enc_pkg::*;
#(
  parameter int AW      = 6,
  parameter int NOP_PAD = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_start,
  input  logic [AW-1:0] base_addr,
  input  logic          load_done,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [3:0]    req_op,
  input  logic [4:0]    req_rs,
  input  logic [4:0]    req_rt,
  input  logic [4:0]    req_rd,
  input  logic [15:0]   req_imm,
  input  logic [25:0]   req_target,
  output logic          imem_we,
  input  logic          imem_wready,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          busy,
  output logic          done,
  output logic          full,
  output logic          err_illegal
);

  localparam logic [AW-1:0] LAST = {AW{1'b1}};

  state_e        state_q;
  logic          out_vld_q;
  logic [31:0]   out_word_q;
  logic [AW-1:0] addr_q;
  logic          full_q;
  logic          err_q;

  logic [31:0] enc_word;
  logic        enc_ill;
  logic        enc_br;

  instr_word_pack u_pack (
    .op        (req_op),
    .rs        (req_rs),
    .rt        (req_rt),
    .rd        (req_rd),
    .imm       (req_imm),
    .target    (req_target),
    .word      (enc_word),
    .illegal   (enc_ill),
    .is_branch (enc_br)
  );

  logic wr_fire, at_last, room, pad_block, accept;

  assign wr_fire = out_vld_q && imem_wready;
  assign at_last = (addr_q == LAST);
  // A word pending at the last address leaves no slot to refill into.
  assign room    = !out_vld_q || (imem_wready && !at_last);

`ifdef INSTR_ENC_NOP_PAD_EN
  logic       out_br_q;
  logic [7:0] pad_cnt_q;
  assign pad_block = (pad_cnt_q != 8'd0) || (out_vld_q && out_br_q);
`else
  logic unused_pad;
  assign unused_pad = enc_br ^ (NOP_PAD != 0);
  assign pad_block  = 1'b0;
`endif

  assign req_ready = (state_q == S_LOAD) && !full_q && room && !pad_block;
  assign accept    = req_valid && req_ready;

  assign imem_we     = out_vld_q;
  assign imem_addr   = addr_q;
  assign imem_wdata  = out_word_q;
  assign busy        = (state_q == S_LOAD) || (state_q == S_DRAIN);
  assign done        = (state_q == S_DONE);
  assign full        = full_q;
  assign err_illegal = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      out_vld_q  <= 1'b0;
      out_word_q <= 32'h0;
      addr_q     <= '0;
      full_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef INSTR_ENC_NOP_PAD_EN
      out_br_q   <= 1'b0;
      pad_cnt_q  <= 8'd0;
`endif
    end else begin
      if (wr_fire) begin
        out_vld_q <= 1'b0;
        if (at_last) full_q <= 1'b1;
        else         addr_q <= addr_q + 1'b1;
`ifdef INSTR_ENC_NOP_PAD_EN
        if (out_br_q && !at_last) pad_cnt_q <= 8'(NOP_PAD);
`endif
      end

      if (accept) begin
        if (enc_ill) err_q <= 1'b1;
        else begin
          out_vld_q  <= 1'b1;
          out_word_q <= enc_word;
`ifdef INSTR_ENC_NOP_PAD_EN
          out_br_q   <= enc_br;
`endif
        end
      end

`ifdef INSTR_ENC_NOP_PAD_EN
      if (full_q) pad_cnt_q <= 8'd0;
      else if (pad_cnt_q != 8'd0 && (!out_vld_q || (wr_fire && !at_last))) begin
        out_vld_q  <= 1'b1;
        out_word_q <= NOP_WORD;
        out_br_q   <= 1'b0;
        pad_cnt_q  <= pad_cnt_q - 8'd1;
      end
`endif

      case (state_q)
        S_IDLE, S_DONE: if (load_start) begin
          state_q   <= S_LOAD;
          addr_q    <= base_addr;
          full_q    <= 1'b0;
          err_q     <= 1'b0;
          out_vld_q <= 1'b0;
        end
        S_LOAD:  if (load_done) state_q <= S_DRAIN;
        S_DRAIN: begin
`ifdef INSTR_ENC_NOP_PAD_EN
          if (!out_vld_q && pad_cnt_q == 8'd0) state_q <= S_DONE;
`else
          if (!out_vld_q) state_q <= S_DONE;
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Directed bench for instr_stream_encoder (AW=3 so the full boundary is reachable).
module tb_instr_stream_encoder;

  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset, load_start, load_done, req_valid, imem_wready;
  logic [AW-1:0] base_addr;
  logic [3:0]    req_op;
  logic [4:0]    req_rs, req_rt, req_rd;
  logic [15:0]   req_imm;
  logic [25:0]   req_target;
  logic          req_ready, imem_we, busy, done, full, err_illegal;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;

  instr_stream_encoder #(.AW(AW), .NOP_PAD(2)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .base_addr(base_addr),
    .load_done(load_done), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
    .req_imm(req_imm), .req_target(req_target), .imem_we(imem_we),
    .imem_wready(imem_wready), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .full(full), .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int          wa[$];
  logic [31:0] wd[$];

  // Inputs change at posedge+1, so the negedge sees what the next edge commits.
  always @(negedge clk)
    if (!reset && imem_we && imem_wready) begin
      wa.push_back(int'(imem_addr));
      wd.push_back(imem_wdata);
    end

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Entered and left at posedge+1.
  task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                      input int bound, output bit ok);
    req_valid = 1'b1; req_op = op; req_rs = rs; req_rt = rt; req_rd = rd;
    req_imm = imm; req_target = tgt;
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      #2;
      ok = req_ready;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic send_exp(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
    bit ok;
    send(op, rs, rt, rd, imm, tgt, 20, ok);
    chk("req_accepted", 32'(ok), 32'd1);
  endtask

  task automatic load(input logic [AW-1:0] b);
    load_start = 1'b1; base_addr = b;
    tick(1);
    load_start = 1'b0;
    wa.delete(); wd.delete();
  endtask

  task automatic finish_load();
    load_done = 1'b1;
    tick(1);
    load_done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) tick(1);
    chk("done_after_drain", 32'(done), 32'd1);
    chk("busy_after_drain", 32'(busy), 32'd0);
  endtask

  task automatic chk_log(input int idx, input int a, input logic [31:0] d);
    if (wa.size() > idx) begin
      chk("wr_addr", 32'(wa[idx]), 32'(a));
      chk("wr_data", wd[idx], d);
    end else chk("wr_missing", 32'(wa.size()), 32'(idx + 1));
  endtask

  vec_t tbl[8];
  bit   ok;

  initial begin
    tbl[0] = '{4'd0,  5'd1,  5'd2, 5'd3,  16'h0000, 32'h1022_1820}; // ADD
    tbl[1] = '{4'd1,  5'd4,  5'd5, 5'd6,  16'h0000, 32'h1085_3022}; // SUB
    tbl[2] = '{4'd3,  5'd31, 5'd0, 5'd31, 16'h0000, 32'h13E0_F825}; // OR
    tbl[3] = '{4'd5,  5'd1,  5'd1, 5'd1,  16'h0000, 32'h1C21_0800}; // SLTO
    tbl[4] = '{4'd6,  5'd2,  5'd3, 5'd0,  16'hFFFF, 32'h2443_FFFF}; // XORI
    tbl[5] = '{4'd9,  5'd7,  5'd5, 5'd0,  16'hABCD, 32'h1405_ABCD}; // LUI
    tbl[6] = '{4'd8,  5'd3,  5'd4, 5'd0,  16'h1234, 32'h1864_1234}; // ANDI
    tbl[7] = '{4'd14, 5'd9,  5'd9, 5'd9,  16'h5555, 32'h1000_0000}; // NOP

    reset = 1'b1; load_start = 0; load_done = 0; req_valid = 0; imem_wready = 1'b1;
    base_addr = '0; req_op = 0; req_rs = 0; req_rt = 0; req_rd = 0;
    req_imm = 0; req_target = 0;
    tick(2);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_imem_we", 32'(imem_we), 0);
    chk("rst_imem_addr", 32'(imem_addr), 0);
    chk("rst_imem_wdata", imem_wdata, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_err", 32'(err_illegal), 0);
    reset = 1'b0;
    load_done = 1'b1;
    tick(1);
    load_done = 1'b0;
    chk("idle_ignores_done", 32'(busy | done), 0);

    // Table: every word checked one cycle after acceptance, then against the write log.
    load(3'd0);
    chk("busy_in_load", 32'(busy), 1);
    for (int i = 0; i < 8; i++) begin
      send_exp(tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].imm, 26'd0);
      chk("lat_we", 32'(imem_we), 1);
      chk("lat_addr", 32'(imem_addr), 32'(i));
      chk("lat_data", imem_wdata, tbl[i].exp);
    end
    tick(2);
    chk("tbl_nwrites", 32'(wa.size()), 8);
    for (int i = 0; i < 8; i++) chk_log(i, i, tbl[i].exp);
    chk("tbl_full", 32'(full), 1);
    finish_load();

    // Backpressure: SW held while memory stalls, a second request waits.
    load(3'd2);
    imem_wready = 1'b0;
    send_exp(4'd11, 5'd2, 5'd4, 5'd0, 16'h0010, 26'd0);
    req_valid = 1'b1; req_op = 4'd0; req_rs = 5'd1; req_rt = 5'd2; req_rd = 5'd3;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_we", 32'(imem_we), 1);
      chk("bp_addr", 32'(imem_addr), 2);
      chk("bp_data", imem_wdata, 32'h0444_0010);
      chk("bp_ready", 32'(req_ready), 0);
      tick(1);
    end
    chk("bp_no_write", 32'(wa.size()), 0);
    imem_wready = 1'b1;
    send_exp(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'd0);
    tick(2);
    chk_log(0, 2, 32'h0444_0010);
    chk_log(1, 3, 32'h1022_1820);
    finish_load();

    // Full: base 6 leaves two slots; the third request must stall.
    load(3'd6);
    send_exp(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'd0);
    send_exp(4'd1, 5'd4, 5'd5, 5'd6, 16'h0, 26'd0);
    send(4'd3, 5'd1, 5'd1, 5'd1, 16'h0, 26'd0, 6, ok);
    chk("full_reject", 32'(ok), 0);
    send(4'd0, 5'd1, 5'd1, 5'd1, 16'h0, 26'd0, 3, ok);
    chk("full_reject2", 32'(ok), 0);
    chk("full_flag", 32'(full), 1);
    chk("full_nwrites", 32'(wa.size()), 2);
    chk_log(0, 6, 32'h1022_1820);
    chk_log(1, 7, 32'h1085_3022);
    finish_load();
    chk("full_no_wrap", 32'(wa.size()), 2);

    // Illegal op between two ADDs leaves no address gap.
    load(3'd0);
    chk("ld_clears_full", 32'(full), 0);
    send_exp(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'd0);
    send_exp(4'd15, 5'd1, 5'd2, 5'd3, 16'h0, 26'd0);
    chk("ill_err", 32'(err_illegal), 1);
    send_exp(4'd0, 5'd1, 5'd2, 5'd4, 16'h0, 26'd0);
    tick(2);
    chk("ill_nwrites", 32'(wa.size()), 2);
    chk_log(0, 0, 32'h1022_1820);
    chk_log(1, 1, 32'h1022_2020);
    finish_load();
    chk("ill_sticky", 32'(err_illegal), 1);
    load(3'd0);
    chk("ill_cleared", 32'(err_illegal), 0);

`ifdef INSTR_ENC_NOP_PAD_EN
    // J pads two NOPs; the following ADD lands after them.
    send_exp(4'd13, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000040);
    send_exp(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'd0);
    tick(2);
    chk("pad_nwrites", 32'(wa.size()), 4);
    chk_log(0, 0, 32'h0C00_0040);
    chk_log(1, 1, 32'h1000_0000);
    chk_log(2, 2, 32'h1000_0000);
    chk_log(3, 3, 32'h1022_1820);
`else
    // Branch forms without padding are consecutive.
    send_exp(4'd12, 5'd1, 5'd2, 5'd0, 16'h0003, 26'd0);
    send_exp(4'd13, 5'd0, 5'd0, 5'd0, 16'h0, 26'h3FFFFFF);
    tick(2);
    chk("br_nwrites", 32'(wa.size()), 2);
    chk_log(0, 0, 32'h0822_0003);
    chk_log(1, 1, 32'h0FFF_FFFF);
`endif
    finish_load();

    // Reset while a write is stalled drops it.
    load(3'd0);
    imem_wready = 1'b0;
    send_exp(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'd0);
    chk("rm_we_before", 32'(imem_we), 1);
    reset = 1'b1;
    tick(1);
    chk("rm_we", 32'(imem_we), 0);
    chk("rm_busy", 32'(busy), 0);
    chk("rm_done", 32'(done), 0);
    chk("rm_ready", 32'(req_ready), 0);
    reset = 1'b0;
    imem_wready = 1'b1;
    tick(2);
    chk("rm_no_write", 32'(wa.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
